scan_sequencer: RTL and testbench
=================================

Name: scan_sequencer

Overview:
Time-multiplexed channel scanner that drives the 3-bit select and enable inputs of the team's 3-to-8 decoder. It steps through the channels enabled in an 8-bit mask and holds each one for a programmable dwell time. A one-cycle blanking gap separates channels so that no two decoder outputs ever overlap. It sits directly upstream of the decoder in LED/7-segment digit-multiplexing and channel-polling paths.

Parameters:
DWELL_W, 16, width of the dwell-count input and the internal dwell counter
NUM_CH, 8, number of channels; fixed at 8 to match the 3-bit select (not overridable)

Ports:
clk  input  1  single system clock; all logic on its rising edge
rst  input  1  reset, synchronous and active-high
start  input  1  one-cycle request to begin scanning
stop  input  1  abort request; returns the block to idle
mode_cont  input  1  1 = continuous scanning, 0 = one-shot (a single frame)
mask  input  8  channel enable mask; bit i set means channel i is scanned
dwell  input  DWELL_W  cycles each channel stays enabled; value 0 is treated as 1
sel  output  3  channel index, feeds the decoder select input
sel_en  output  1  feeds the decoder enable input
busy  output  1  high whenever state is not IDLE
frame_done  output  1  one-cycle pulse after the last enabled channel of a frame

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE, sel=0, sel_en=0, busy=0, frame_done=0.
  - Dwell counter and captured mask/dwell cleared.
  - rst overrides every other input.
- States: IDLE, SCAN, BLANK.
- IDLE:
  - sel_en=0; sel holds its last value.
  - start=1 with mask!=0 and stop=0 captures mask and dwell.
  - Next cycle: state=SCAN, sel = lowest set bit of mask, sel_en=1, busy=1. Latency from start to sel_en is exactly 1 cycle.
  - start with mask==0 is ignored (stays IDLE, no pulse).
- SCAN:
  - sel_en=1 for exactly max(dwell,1) consecutive cycles; counter loads dwell-1 and decrements to 0.
  - When the counter reaches 0, the next state is BLANK.
- BLANK: exactly 1 cycle, sel_en=0, sel updates to the next channel.
  - Next channel = next set bit of the captured mask strictly above the current sel, wrapping past 7 to 0.
  - If the wrap occurs, or the mask has a single bit, this is the end of a frame and frame_done=1 during this BLANK cycle.
  - End of frame, one-shot (mode_cont=0): the state after BLANK is IDLE; busy drops on that cycle.
  - End of frame, continuous (mode_cont=1): mask and dwell inputs are re-sampled at the frame end.
    - New mask==0: go to IDLE after BLANK.
    - Otherwise: return to SCAN at the lowest set bit of the new mask.
  - Not end of frame: return to SCAN with the updated sel.
- Mid-frame changes to mask or dwell have no effect until the next start or the next frame boundary.
- start while busy is ignored.
- stop=1 in any state:
  - Next cycle: state=IDLE, sel_en=0, busy=0.
  - frame_done is not asserted, even if stop coincides with a frame end.
  - stop wins over start in the same cycle.
- Single-channel mask (e.g. 8'h10): period is dwell+1 cycles, sel is constant, frame_done fires every period.
- sel changes only in BLANK or on the IDLE->SCAN transition, never while sel_en=1. This guarantees glitch-free decoder outputs.
- The dwell counter never wraps. Maximum dwell is 2^DWELL_W-1.

Decomposition:
- Shared package/header holds:
  - State encodings: IDLE=2'd0, SCAN=2'd1, BLANK=2'd2.
  - NUM_CH=8 and SEL_W=3 constants.
- Sub-module next_ch_find, purely combinational:
  - Inputs: mask[7:0], cur[2:0].
  - Outputs: nxt[2:0], wrap, first[2:0] (lowest set bit).
  - Instantiated once. The FSM, counter and output registers stay in scan_sequencer.

Test Plan:
1. rst=1 for 2 cycles with start=1 -> sel=0, sel_en=0, busy=0, frame_done=0 throughout.
2. mask=8'b1010_0101, dwell=3, mode_cont=0, start pulse -> sel sequence 0,2,5,7:
   - each sel held with sel_en=1 for 3 cycles, 1-cycle gaps between channels;
   - frame_done single pulse in the BLANK after ch7;
   - busy low on the next cycle; total busy = 16 cycles.
3. mask=8'h10, dwell=0, mode_cont=1 -> sel=4 constant; sel_en pattern 1,0 repeating; frame_done every 2 cycles.
4. Continuous, mask=8'h03, dwell=2; switch mask to 8'h80 mid-frame -> current frame completes over ch0,1; next frame scans only ch7.
5. stop asserted during the 2nd dwell cycle of ch2 -> next cycle sel_en=0, busy=0, no frame_done; a new start restarts at the lowest mask bit.
6. start with mask=0 -> no state change. start during busy -> sequence unchanged. start+stop together in IDLE -> remains IDLE.

Source files
------------

// File: rtl/scan_sequencer_pkg.sv
// Shared encodings and constants for the channel scan sequencer.
// Imported by the sequencer and its next-channel finder.
package scan_sequencer_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;

endpackage

// File: rtl/scan_sequencer_next_ch_find.sv
// Combinational search for the next enabled channel above cur
// (wrapping past the top) and for the lowest enabled channel.
module next_ch_find
    import scan_sequencer_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  nxt,
    output logic              wrap,
    output logic [SEL_W-1:0]  first
);

    logic [SEL_W-1:0] idx;
    logic             found;

    always_comb begin
        nxt   = cur;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i < NUM_CH; i++) begin
            idx = cur + SEL_W'(i);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        first = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) first = SEL_W'(i);
        end
    end

    // A single-bit mask finds cur itself, which also counts as a wrap.
    assign wrap = (nxt <= cur);

endmodule

// File: rtl/scan_sequencer.sv
// Time-multiplexed channel scanner driving a 3-to-8 decoder select,
// with a one-cycle blanking gap between consecutive channels.
module scan_sequencer
    import scan_sequencer_pkg::*;
#(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [NUM_CH-1:0]  mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_en,
    output logic               busy,
    output logic               frame_done
);

    state_t             state, state_n;
    logic [SEL_W-1:0]   sel_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [DWELL_W-1:0] cap_dwell, cap_dwell_n;
    logic [NUM_CH-1:0]  cap_mask, cap_mask_n;
    logic [NUM_CH-1:0]  fmask;
    logic               fd_n;
    logic               last, last_n;
    logic [SEL_W-1:0]   nxt, first;
    logic               wrap;

    function automatic logic [DWELL_W-1:0] reload(
        input logic [DWELL_W-1:0] d
    );
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

    // In IDLE the finder looks at the live mask to pick the first channel.
    assign fmask = (state == IDLE) ? mask : cap_mask;

    next_ch_find u_find (
        .mask  (fmask),
        .cur   (sel),
        .nxt   (nxt),
        .wrap  (wrap),
        .first (first)
    );

    always_comb begin
        state_n     = state;
        sel_n       = sel;
        cnt_n       = cnt;
        cap_mask_n  = cap_mask;
        cap_dwell_n = cap_dwell;
        fd_n        = 1'b0;
        last_n      = last;
        if (stop) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && mask != '0) begin
                        state_n     = SCAN;
                        sel_n       = first;
                        cap_mask_n  = mask;
                        cap_dwell_n = dwell;
                        cnt_n       = reload(dwell);
                    end
                end
                SCAN: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - DWELL_W'(1);
                    end else begin
                        state_n = BLANK;
                        sel_n   = nxt;
                        fd_n    = wrap;
                        last_n  = 1'b0;
                        if (wrap) begin
                            if (mode_cont) begin
                                cap_mask_n  = mask;
                                cap_dwell_n = dwell;
                                last_n      = (mask == '0);
                            end else begin
                                last_n = 1'b1;
                            end
                        end
                    end
                end
                BLANK: begin
                    if (last) begin
                        state_n = IDLE;
                    end else begin
                        state_n = SCAN;
                        cnt_n   = reload(cap_dwell);
                        // A new frame begins at the lowest bit of the re-sampled mask.
                        if (frame_done) sel_n = first;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            cnt        <= '0;
            cap_mask   <= '0;
            cap_dwell  <= '0;
            frame_done <= 1'b0;
            last       <= 1'b0;
        end else begin
            state      <= state_n;
            sel        <= sel_n;
            cnt        <= cnt_n;
            cap_mask   <= cap_mask_n;
            cap_dwell  <= cap_dwell_n;
            frame_done <= fd_n;
            last       <= last_n;
        end
    end

    assign sel_en = (state == SCAN);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed testbench for scan_sequencer with hand-computed traces.
module tb_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode_cont = 1'b0;
    logic [7:0]  mask = '0;
    logic [15:0] dwell = '0;
    logic [2:0]  sel;
    logic        sel_en;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    scan_sequencer #(.DWELL_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode_cont  (mode_cont),
        .mask       (mask),
        .dwell      (dwell),
        .sel        (sel),
        .sel_en     (sel_en),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        mask  = 8'hff;
        dwell = 16'd5;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({sel, sel_en, busy, frame_done} !== 6'b0) begin
                fails++;
                $display("FAIL reset cyc%0d: got sel=%0d en=%b busy=%b fd=%b, want all 0",
                         k, sel, sel_en, busy, frame_done);
            end
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_oneshot();
        bit         en_e[17]  = '{1,1,1,0,1,1,1,0,1,1,1,0,1,1,1,0,0};
        logic [2:0] sel_e[17] = '{0,0,0,2,2,2,2,5,5,5,5,7,7,7,7,0,0};
        logic [2:0] exp;
        int         busy_cnt = 0;
        @(negedge clk);
        mask      = 8'b1010_0101;
        dwell     = 16'd3;
        mode_cont = 1'b0;
        start     = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            start = 1'b0;
            exp = {en_e[k], 1'(k < 16), 1'(k == 15)};
            busy_cnt += int'(busy);
            checks++;
            if ({sel_en, busy, frame_done} !== exp || (en_e[k] && sel !== sel_e[k])) begin
                fails++;
                $display("FAIL oneshot cyc%0d: got sel=%0d en/busy/fd=%b, want sel=%0d en/busy/fd=%b",
                         k, sel, {sel_en, busy, frame_done}, sel_e[k], exp);
            end
        end
        checks++;
        if (busy_cnt != 16) begin
            fails++;
            $display("FAIL oneshot_busy_len: got %0d, want 16", busy_cnt);
        end
    endtask

    task automatic test_single_cont();
        @(negedge clk);
        mask      = 8'h10;
        dwell     = 16'd0;
        mode_cont = 1'b1;
        start     = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (sel !== 3'd4 || sel_en !== (k % 2 == 0) || frame_done !== (k % 2 == 1)
                || busy !== 1'b1) begin
                fails++;
                $display("FAIL single cyc%0d: got sel=%0d en=%b fd=%b busy=%b, want sel=4 en=%b fd=%b busy=1",
                         k, sel, sel_en, frame_done, busy, k % 2 == 0, k % 2 == 1);
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if ({sel_en, busy, frame_done} !== 3'b000) begin
            fails++;
            $display("FAIL single_stop: got en/busy/fd=%b, want 000", {sel_en, busy, frame_done});
        end
    endtask

    task automatic test_mask_switch();
        bit         en_e[11]  = '{1,1,0,1,1,0,1,1,0,1,1};
        bit         fd_e[11]  = '{0,0,0,0,0,1,0,0,1,0,0};
        logic [2:0] sel_e[11] = '{0,0,0,1,1,0,7,7,0,7,7};
        @(negedge clk);
        mask      = 8'h03;
        dwell     = 16'd2;
        mode_cont = 1'b1;
        start     = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (sel_en !== en_e[k] || frame_done !== fd_e[k] || busy !== 1'b1
                || (en_e[k] && sel !== sel_e[k])) begin
                fails++;
                $display("FAIL mask_switch cyc%0d: got sel=%0d en=%b fd=%b busy=%b, want sel=%0d en=%b fd=%b busy=1",
                         k, sel, sel_en, frame_done, busy, sel_e[k], en_e[k], fd_e[k]);
            end
            if (k == 0) mask = 8'h80;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL mask_switch_stop: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_stop();
        bit         en_e[6]  = '{1,1,1,0,1,1};
        logic [2:0] sel_e[6] = '{1,1,1,2,2,2};
        @(negedge clk);
        mask      = 8'b0000_0110;
        dwell     = 16'd3;
        mode_cont = 1'b0;
        start     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (sel_en !== en_e[k] || busy !== 1'b1 || (en_e[k] && sel !== sel_e[k])) begin
                fails++;
                $display("FAIL stop_pre cyc%0d: got sel=%0d en=%b busy=%b, want sel=%0d en=%b busy=1",
                         k, sel, sel_en, busy, sel_e[k], en_e[k]);
            end
        end
        stop = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            stop = 1'b0;
            checks++;
            if ({sel_en, busy, frame_done} !== 3'b000) begin
                fails++;
                $display("FAIL stop_post cyc%0d: got en/busy/fd=%b, want 000",
                         k, {sel_en, busy, frame_done});
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (sel !== 3'd1 || sel_en !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL stop_restart: got sel=%0d en=%b busy=%b, want sel=1 en=1 busy=1",
                     sel, sel_en, busy);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_ignored_starts();
        bit         en_e[6]  = '{1,0,1,0,0,0};
        bit         bz_e[6]  = '{1,1,1,1,0,0};
        bit         fd_e[6]  = '{0,0,0,1,0,0};
        logic [2:0] sel_e[6] = '{0,7,7,0,0,0};
        mask  = 8'h00;
        start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({sel_en, busy, frame_done} !== 3'b000) begin
                fails++;
                $display("FAIL zero_mask cyc%0d: got en/busy/fd=%b, want 000",
                         k, {sel_en, busy, frame_done});
            end
        end
        mask  = 8'hff;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if ({sel_en, busy} !== 2'b00) begin
            fails++;
            $display("FAIL start_stop_idle: got en/busy=%b, want 00", {sel_en, busy});
        end
        mask      = 8'h81;
        dwell     = 16'd1;
        mode_cont = 1'b0;
        start     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (sel_en !== en_e[k] || busy !== bz_e[k] || frame_done !== fd_e[k]
                || (en_e[k] && sel !== sel_e[k])) begin
                fails++;
                $display("FAIL busy_start cyc%0d: got sel=%0d en=%b busy=%b fd=%b, want sel=%0d en=%b busy=%b fd=%b",
                         k, sel, sel_en, busy, frame_done, sel_e[k], en_e[k], bz_e[k], fd_e[k]);
            end
            if (k == 0 || k == 2) begin
                start = 1'b1;
                mask  = 8'h02;
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_single_cont();
        test_mask_switch();
        test_stop();
        test_ignored_starts();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
